// File: rtl/vga_timing.sv
// Raster timing generator: registered pixel/line counters with sync, blank
// and frame-start flags, advanced by a pixel enable.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter logic        SYNC_ACT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK_BEG  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLNK_BEG  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        h_wrap;
  logic        frame_wrap;
  logic        hsync_next;
  logic        vsync_next;
  logic        hblnk_next;
  logic        vblnk_next;

  // Flags decode the next count so they land in the same register stage as it.
  always_comb begin
    h_wrap     = (hcount_out == H_LAST);
    frame_wrap = h_wrap && (vcount_out == V_LAST);
    h_next     = h_wrap ? '0 : hcount_out + 11'd1;
    v_next     = vcount_out;
    if (h_wrap) begin
      v_next = (vcount_out == V_LAST) ? '0 : vcount_out + 11'd1;
    end
    hblnk_next = (h_next >= H_BLNK_BEG);
    vblnk_next = (v_next >= V_BLNK_BEG);
    hsync_next = ((h_next >= H_SYNC_BEG) && (h_next <= H_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_next = ((v_next >= V_SYNC_BEG) && (v_next <= V_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      hsync_out   <= ~SYNC_ACT;
      vsync_out   <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hcount_out  <= h_next;
      vcount_out  <= v_next;
      hblnk_out   <= hblnk_next;
      vblnk_out   <= vblnk_next;
      hsync_out   <= hsync_next;
      vsync_out   <= vsync_next;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the raster timing that every VGA drawing stage consumes: hcount/vcount, hsync/vsync and hblnk/vblnk.
- Sits at the head of the VGA pipeline and feeds the background, rectangle and overlay drawers directly.
- Default geometry is 1024x768 @ 60 Hz (65 MHz pixel clock), matching HOR_PIXELS/VER_PIXELS in vga_pkg.
- Adds a pixel-enable input and a frame-start strobe so that downstream stages and the game logic can sync to frames.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); line total H_TOTAL = 1344
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); frame total V_TOTAL = 806
SYNC_ACT, 1'b1, active level driven on hsync_out/vsync_out during the sync pulse

Ports:
clk  in  1  pixel clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
pix_en  in  1  advance enable; when 0 every output holds its value
vcount_out  out  11  current line, 0..V_TOTAL-1
vsync_out  out  1  vertical sync
vblnk_out  out  1  vertical blanking
hcount_out  out  11  current pixel in line, 0..H_TOTAL-1
hsync_out  out  1  horizontal sync
hblnk_out  out  1  horizontal blanking
frame_start  out  1  one-cycle strobe marking the first pixel of a frame

Behaviour:
- All outputs are registers. No output may be a combinational decode of the counter registers.
- Decodes are computed from the next-count values, so each registered flag is coherent with the hcount/vcount value on the same cycle.
- Reset (rst=0, asynchronous) forces every output to a fixed state, regardless of clk or pix_en:
  - hcount_out = 0, vcount_out = 0
  - hblnk_out = 0, vblnk_out = 0
  - hsync_out = vsync_out = ~SYNC_ACT
  - frame_start = 0
- Reset release: the first clk edge with rst=1 and pix_en=1 moves to (h=1, v=0). Pixel (0,0) is therefore presented during reset and the cycle after it.
- Horizontal counter, on each edge with pix_en=1:
  - if hcount_out == H_TOTAL-1: hcount goes to 0, else hcount+1.
- Vertical counter advances only on the horizontal wrap:
  - if vcount_out == V_TOTAL-1: vcount goes to 0, else vcount+1.
  - Both counters wrap on the same edge at (H_TOTAL-1, V_TOTAL-1), giving (0,0).
- Flags, as functions of the count values on the same cycle (h = hcount_out, v = vcount_out):
  - hblnk_out = (h >= H_ACTIVE)
  - hsync_out = SYNC_ACT iff H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1 (1048..1183 by default)
  - vblnk_out = (v >= V_ACTIVE)
  - vsync_out = SYNC_ACT iff V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1 (771..776 by default)
  - vsync/vblnk change only at line boundaries, i.e. on the same edge that sets hcount to 0.
- frame_start is 1 for exactly one pix_en-qualified cycle: the cycle in which (h,v) becomes (0,0) through the counter wrap.
  - It clears on the next edge with pix_en=1.
  - It is not asserted on reset release.
  - While pix_en=0 it holds its value.
- pix_en=0 freezes counters and all flags with no lost or repeated state. Resuming continues from the frozen count.
- Counters are 11 bits and never exceed H_TOTAL-1 or V_TOTAL-1. Out-of-range values cannot occur because only reset and the wrap write them.
- Reset asserted mid-line or mid-frame returns all outputs to the reset state immediately, without waiting for clk.
- Parameter legality is required, not checked: H_TOTAL <= 2048 and V_TOTAL <= 2048; each porch and sync width >= 1.

Test Plan:
1. Hold rst=0, then release with pix_en=1. Required:
   - During reset: h=0, v=0, hblnk=vblnk=0, hsync=vsync=0, frame_start=0.
   - 1023 edges after release: h=1023, hblnk=0.
   - Next edge: h=1024, hblnk=1.
2. Run one line. Required:
   - hsync=1 exactly for h=1048..1183 (136 cycles).
   - After h=1343 the next edge gives h=0, v=1, hblnk=0.
3. Run one full frame. Required:
   - vblnk=1 for v=768..805.
   - vsync=1 exactly for v=771..776, 6 lines of 1344 cycles each.
   - (1343,805) followed by (0,0) with frame_start=1 for one cycle.
   - Consecutive frame_start pulses are 1,083,264 enabled cycles apart.
4. Toggle pix_en pseudo-randomly: low for 3 cycles at h=1047, and across the (1343,805) wrap. Required:
   - All outputs hold while pix_en=0.
   - The sync, blank and frame_start sequence is identical to the pix_en=1 run when indexed by enabled cycles.
5. Assert rst=0 asynchronously between edges at (h=600, v=400). Required:
   - Outputs go to the reset values before the next clk edge.
   - After release, counting restarts from (0,0) with no frame_start.
6. Instantiate with SYNC_ACT=0. Required: hsync/vsync are inverted relative to scenarios 2 and 3; counts and blanks are unchanged.
